// File: rtl/instr_encoder_loader_if.sv
// Instruction-field stream from a program source into the encoder/loader.
// Master drives symbolic fields with valid/last; slave answers with ready.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        op_kind;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] target;

  modport master (
    output in_valid, in_last, op_kind, rs, rt, rd, funct, imm, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, op_kind, rs, rt, rd, funct, imm, target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction fields into MIPS words and writes them sequentially to imem.
// Optional macro ENC_JUMP_EN enables op_kind=4 (j); otherwise op_kind=4 is illegal.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  instr_encoder_loader_if.slave       in_if,
  output logic                        imem_we,
  output logic [ADDR_W-1:0]           imem_addr,
  output logic [31:0]                 imem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W:0]             count,
  output logic                        err_illegal,
  output logic                        err_full
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_ill_q, err_ill_d;
  logic              err_full_q, err_full_d;

  logic              legal;
  logic [31:0]       enc;
  logic [ADDR_W:0]   beq_off;
  logic              accept;
  logic              at_top;

  // Branch offset is relative to pc+1, formed one bit wider so it stays signed-correct.
  always_comb begin
    beq_off = {1'b0, in_if.target} - ({1'b0, pc_q} + (ADDR_W+1)'(1));
    legal   = 1'b1;
    enc     = '0;
    case (in_if.op_kind)
      3'd0: enc = {6'h00, in_if.rs, in_if.rt, in_if.rd, 5'd0, in_if.funct};
      3'd1: enc = {6'h23, in_if.rs, in_if.rt, in_if.imm};
      3'd2: enc = {6'h2B, in_if.rs, in_if.rt, in_if.imm};
      3'd3: enc = {6'h04, in_if.rs, in_if.rt, 16'($signed(beq_off))};
`ifdef ENC_JUMP_EN
      3'd4: enc = {6'h02, 26'(in_if.target)};
`endif
      default: legal = 1'b0;
    endcase
  end

  assign in_if.in_ready = (state_q == StLoad);
  assign accept         = in_if.in_valid & in_if.in_ready;
  assign at_top         = &pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_ill_d  = err_ill_q;
    err_full_d = err_full_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          pc_d       = base_addr;
          count_d    = '0;
          err_ill_d  = 1'b0;
          err_full_d = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (legal) begin
            we_d    = 1'b1;
            addr_d  = pc_q;
            wdata_d = enc;
            count_d = count_q + (ADDR_W+1)'(1);
            if (!at_top) pc_d = pc_q + ADDR_W'(1);
          end else begin
            err_ill_d = 1'b1;
          end
          // The top word is written but never wraps; running out of space without in_last
          // is reported as err_full.
          if (in_if.in_last) begin
            state_d = StDrain;
          end else if (legal && at_top) begin
            state_d    = StDrain;
            err_full_d = 1'b1;
          end
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_ill_q  <= 1'b0;
      err_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_ill_q  <= err_ill_d;
      err_full_q <= err_full_d;
    end
  end

  // done coincides with the final write strobe: both are visible in the single DRAIN cycle.
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDrain);
  assign count       = count_q;
  assign err_illegal = err_ill_q;
  assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: one 8-bit-address instance and one 2-bit instance
// for the end-of-memory case.
module tb_instr_encoder_loader;

  logic clk;
  logic rst_n;

  logic        start_a;
  logic [7:0]  base_a;
  logic        we_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic        busy_a;
  logic        done_a;
  logic [8:0]  count_a;
  logic        eill_a;
  logic        efull_a;

  logic        start_b;
  logic [1:0]  base_b;
  logic        we_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic        busy_b;
  logic        done_b;
  logic [2:0]  count_b;
  logic        eill_b;
  logic        efull_b;

  int n_cmp;
  int n_err;

  instr_encoder_loader_if #(.ADDR_W(8)) ia ();
  instr_encoder_loader_if #(.ADDR_W(2)) ib ();

  instr_encoder_loader #(.ADDR_W(8)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_a),
    .base_addr   (base_a),
    .in_if       (ia.slave),
    .imem_we     (we_a),
    .imem_addr   (addr_a),
    .imem_wdata  (wdata_a),
    .busy        (busy_a),
    .done        (done_a),
    .count       (count_a),
    .err_illegal (eill_a),
    .err_full    (efull_a)
  );

  instr_encoder_loader #(.ADDR_W(2)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .base_addr   (base_b),
    .in_if       (ib.slave),
    .imem_we     (we_b),
    .imem_addr   (addr_b),
    .imem_wdata  (wdata_b),
    .busy        (busy_b),
    .done        (done_b),
    .count       (count_b),
    .err_illegal (eill_b),
    .err_full    (efull_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                       input logic [7:0] tg, input logic last);
    ia.in_valid = 1'b1;
    ia.op_kind  = k;
    ia.rs       = s;
    ia.rt       = t;
    ia.rd       = d;
    ia.funct    = f;
    ia.imm      = im;
    ia.target   = tg;
    ia.in_last  = last;
  endtask

  task automatic set_b(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                       input logic [1:0] tg, input logic last);
    ib.in_valid = 1'b1;
    ib.op_kind  = k;
    ib.rs       = s;
    ib.rt       = t;
    ib.rd       = d;
    ib.funct    = f;
    ib.imm      = im;
    ib.target   = tg;
    ib.in_last  = last;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    base_a  = '0;
    base_b  = '0;
    set_a(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 8'd0, 1'b0);
    set_b(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 2'd0, 1'b0);
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    #12;

    chk("rst_ready", ia.in_ready, 0);
    chk("rst_we", we_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_errs", {eill_a, efull_a, eill_b, efull_b}, 0);

    rst_n = 1'b1;
    cyc();

    // First program at base 0
    start_a = 1'b1;
    base_a  = 8'd0;
    cyc();
    start_a = 1'b0;
    chk("ld_busy", busy_a, 1);
    chk("ld_ready", ia.in_ready, 1);
    chk("ld_count0", count_a, 0);

    set_a(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 8'd0, 1'b0);
    cyc();
    chk("r_we", we_a, 1);
    chk("r_addr", addr_a, 0);
    chk("r_wdata", wdata_a, 32'h01095020);
    chk("r_count", count_a, 1);

    set_a(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd4, 8'd0, 1'b0);
    cyc();
    chk("lw_addr", addr_a, 1);
    chk("lw_wdata", wdata_a, 32'h8C080004);

    set_a(3'd2, 5'd16, 5'd8, 5'd0, 6'd0, 16'd8, 8'd0, 1'b0);
    cyc();
    chk("sw_we", we_a, 1);
    chk("sw_addr", addr_a, 2);
    chk("sw_wdata", wdata_a, 32'hAE080008);

    // beq at pc=3 back to 0: offset 0-4 = -4
    set_a(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'd0, 8'd0, 1'b0);
    cyc();
    chk("beqn_addr", addr_a, 3);
    chk("beqn_wdata", wdata_a, 32'h1109FFFC);

    set_a(3'd6, 5'd1, 5'd2, 5'd3, 6'd0, 16'd0, 8'd0, 1'b0);
    cyc();
    chk("ill_we", we_a, 0);
    chk("ill_err", eill_a, 1);
    chk("ill_count", count_a, 4);

    // beq at unchanged pc=4 to 10: offset 10-5 = 5
    set_a(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'd0, 8'd10, 1'b0);
    cyc();
    chk("beqp_we", we_a, 1);
    chk("beqp_addr", addr_a, 4);
    chk("beqp_wdata", wdata_a, 32'h11090005);
    chk("beqp_count", count_a, 5);

    set_a(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 8'd3, 1'b1);
    cyc();
`ifdef ENC_JUMP_EN
    chk("j_we", we_a, 1);
    chk("j_addr", addr_a, 5);
    chk("j_wdata", wdata_a, 32'h08000003);
    chk("j_count", count_a, 6);
`else
    chk("j_we", we_a, 0);
    chk("j_err", eill_a, 1);
    chk("j_count", count_a, 5);
`endif
    chk("last_done", done_a, 1);
    chk("last_ready", ia.in_ready, 0);
    chk("last_busy", busy_a, 1);
    ia.in_valid = 1'b0;
    cyc();
    chk("idle_done", done_a, 0);
    chk("idle_busy", busy_a, 0);
    chk("idle_err_sticky", eill_a, 1);

    // Second program at base 2; start clears errors, start while busy is ignored
    start_a = 1'b1;
    base_a  = 8'd2;
    cyc();
    start_a = 1'b0;
    chk("st2_errclr", eill_a, 0);
    chk("st2_count", count_a, 0);

    set_a(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'd0, 8'd0, 1'b0);
    cyc();
    chk("beq2_addr", addr_a, 2);
    chk("beq2_wdata", wdata_a, 32'h1109FFFD);

    ia.in_valid = 1'b0;
    start_a     = 1'b1;
    base_a      = 8'd100;
    cyc();
    start_a = 1'b0;
    chk("gap_we", we_a, 0);
    chk("gap_busy", busy_a, 1);

    set_a(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'd0, 8'd5, 1'b1);
    cyc();
    chk("beq3_addr", addr_a, 3);
    chk("beq3_wdata", wdata_a, 32'h11090001);
    chk("beq3_done", done_a, 1);
    chk("beq3_count", count_a, 2);
    ia.in_valid = 1'b0;
    cyc();
    chk("end2_busy", busy_a, 0);

    // Small memory: base 2, three words without in_last
    start_b = 1'b1;
    base_b  = 2'd2;
    cyc();
    start_b = 1'b0;
    set_b(3'd0, 5'd1, 5'd2, 5'd3, 6'h22, 16'd0, 2'd0, 1'b0);
    cyc();
    chk("b1_we", we_b, 1);
    chk("b1_addr", addr_b, 2);
    chk("b1_wdata", wdata_b, 32'h00221822);
    chk("b1_ready", ib.in_ready, 1);
    chk("b1_full", efull_b, 0);

    set_b(3'd1, 5'd3, 5'd4, 5'd0, 6'd0, 16'hFFFF, 2'd0, 1'b0);
    cyc();
    chk("b2_we", we_b, 1);
    chk("b2_addr", addr_b, 3);
    chk("b2_wdata", wdata_b, 32'h8C64FFFF);
    chk("b2_ready", ib.in_ready, 0);
    chk("b2_done", done_b, 1);
    chk("b2_full", efull_b, 1);
    chk("b2_count", count_b, 2);

    set_b(3'd2, 5'd5, 5'd6, 5'd0, 6'd0, 16'd1, 2'd0, 1'b0);
    cyc();
    chk("b3_we", we_b, 0);
    chk("b3_busy", busy_b, 0);
    chk("b3_count", count_b, 2);
    chk("b3_full_sticky", efull_b, 1);
    ib.in_valid = 1'b0;

    // Reset in the middle of a load with a write strobe showing
    start_a = 1'b1;
    base_a  = 8'd7;
    cyc();
    start_a = 1'b0;
    set_a(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 8'd0, 1'b0);
    cyc();
    chk("pre_rst_we", we_a, 1);
    chk("pre_rst_addr", addr_a, 7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", we_a, 0);
    chk("mid_rst_addr", addr_a, 0);
    chk("mid_rst_wdata", wdata_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_ready", ia.in_ready, 0);
    chk("mid_rst_count", count_a, 0);
    ia.in_valid = 1'b0;
    rst_n       = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
